tone_detect: RTL and testbench
==============================

# tone_detect

Receive-side counterpart of the tone generator. It measures the interval between edges of an incoming square wave, such as a buzzer/speaker line looped back or driven from another board, and flags lock when a run of consecutive half-periods matches the target tone within tolerance. It sits between an external pin and control logic. It reports the latest measured half-period and a debounced "tone present" flag.

## Interface
- `HALF`, 28410: target half-period in clk cycles. 25 MHz / 440 Hz / 2 = 28409, plus 1 for the generator's toggle cycle.
- `TOL`, 256: accepted deviation in cycles, inclusive.
- `MATCH_N`, 8: consecutive in-tolerance half-periods required to lock (1..15).
- `W`, 16: counter and measurement width. `HALF+TOL` must be < 2^W.

- `clk`, in, 1: system clock, rising-edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `sp_in`, in, 1: asynchronous tone input.
- `detected`, out, 1: tone locked.
- `half_period`, out, W: last measured edge-to-edge interval in cycles.
- `period_valid`, out, 1: one-cycle pulse when `half_period` updates.

## Operation
- **Input capture:** 2-flop synchronizer `s1`/`s2` plus history flop `s3`, all reset to 0. `edge = s2 ^ s3`; both polarities count.
- **Interval counter `cnt`:**
  - cleared to 0 on every edge cycle;
  - otherwise increments each cycle in TRACK/LOCK;
  - held at 0 in IDLE.
- **Measurement:** `meas = cnt + 1` in the edge cycle. `good = (meas >= HALF-TOL) && (meas <= HALF+TOL)`.
- **Timeout:** asserted when `cnt == HALF+TOL` with no edge in that cycle. The counter cannot pass this value, so it never saturates.
- **FSM states:** IDLE, TRACK, LOCK. Match counter `mcnt` is 4 bits.
  - **IDLE:** on edge -> TRACK, `mcnt`=0, no `period_valid` (no reference edge yet).
  - **TRACK:**
    - edge & good: `mcnt`+1; if the new value == `MATCH_N` -> LOCK.
    - edge & !good: `mcnt`=0, stay in TRACK.
    - timeout: -> IDLE, `mcnt`=0.
  - **LOCK:**
    - edge & good: stay in LOCK.
    - edge & !good: -> TRACK, `mcnt`=0.
    - timeout: -> IDLE.
- **Outputs:**
  - `detected` = 1 exactly while in LOCK, registered.
  - On every edge in TRACK or LOCK: `half_period <= meas` and `period_valid` = 1 for one cycle, whether or not the interval is good.
- **Simultaneous events:** an edge in the timeout cycle counts as an edge; timeout is ignored that cycle.

## Timing
- **Reset values:** `detected`=0, `half_period`=0, `period_valid`=0, state IDLE, `cnt`=0, `mcnt`=0, sync flops 0.
- **`rst_n` low mid-operation:** all of the above apply immediately (asynchronous). On release, the first `sp_in` edge is treated as a reference edge only.
- **Latency:** for a `sp_in` transition meeting setup before clk edge k, the state/outputs update at clk edge k+2.
- **Lock time:** the reference edge plus `MATCH_N` good edges. `detected` rises with the `period_valid` of the `MATCH_N`-th measured interval.
- **Loss of lock:** `detected` falls at the clock edge that registers the bad-interval edge, or `HALF+TOL+1` cycles after the last registered edge on timeout.
- **Constant input:** `sp_in` held constant never produces `period_valid` and never asserts `detected`.

## Test plan
The bench uses `HALF`=20, `TOL`=2, `MATCH_N`=4.

1. **Reset:** hold `rst_n`=0 and toggle `sp_in` -> all outputs 0. Release; `sp_in` stays static for 100 cycles -> no `period_valid`, `detected`=0.
2. **Nominal lock:** toggle `sp_in` every 20 cycles.
   - No pulse on edge 1.
   - `period_valid` pulses on edges 2..N with `half_period`=20.
   - `detected` rises with the pulse of edge 5 and stays high.
3. **Tolerance boundaries:**
   - Intervals 18 and 22 are accepted: lock is reached using a mix of them.
   - Intervals of 17 or 23 are rejected: `half_period` shows 17/23, and `mcnt` restarts.
4. **Bad interval while locked:** after lock, insert one 17-cycle interval -> `detected` falls. Resume 20-cycle intervals -> `detected` rises again after 4 good intervals.
5. **Timeout:** after lock, stop toggling -> `detected` falls 23 cycles after the last registered edge. The next edge produces no `period_valid`; the following edge does.
6. **Async reset in LOCK:** drive `rst_n` low between clock edges -> `detected`, `half_period` and `period_valid` go to 0 without waiting for a clock edge. After release, relock takes 5 edges again.

Source files
------------

// File: rtl/tone_detect.sv
`default_nettype none
// ============================================================================
// Module   : tone_detect
// Brief    : Measures edge-to-edge intervals of an asynchronous square wave
//            and reports lock when MATCH_N consecutive half-periods fall
//            within HALF +/- TOL clock cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tone_detect #(
  parameter int HALF    = 28410,
  parameter int TOL     = 256,
  parameter int MATCH_N = 8,
  parameter int W       = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sp_in,
  output logic         detected,
  output logic [W-1:0] half_period,
  output logic         period_valid
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_LOCK  = 2'd2
  } state_t;

  localparam logic [W-1:0] c_lo    = W'(HALF - TOL);
  localparam logic [W-1:0] c_hi    = W'(HALF + TOL);
  localparam logic [3:0]   c_match = 4'(MATCH_N);

  logic         r_s1, r_s2, r_s3;
  state_t       r_state, w_state_nxt;
  logic [W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]   r_mcnt, w_mcnt_nxt;
  logic [3:0]   w_mcnt_inc;
  logic [W-1:0] w_meas;
  logic         w_edge, w_good, w_timeout, w_pv_nxt;
  logic         r_detected, r_period_valid;
  logic [W-1:0] r_half_period;

  // Either polarity of a synchronized transition marks a half-period boundary.
  assign w_edge     = r_s2 ^ r_s3;
  // The edge cycle itself belongs to the interval, hence the +1.
  assign w_meas     = r_cnt + W'(1);
  assign w_good     = (w_meas >= c_lo) && (w_meas <= c_hi);
  // An edge landing in the timeout cycle wins, so the counter tops out at c_hi.
  assign w_timeout  = (r_cnt == c_hi) && !w_edge;
  assign w_mcnt_inc = r_mcnt + 4'd1;

  // Two-flop synchronizer plus a history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= sp_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Next-state, interval counter and match counter decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mcnt_nxt  = r_mcnt;
    w_pv_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // First edge only establishes a reference; nothing to measure yet.
        w_cnt_nxt = '0;
        if (w_edge) begin
          w_state_nxt = S_TRACK;
          w_mcnt_nxt  = 4'd0;
        end
      end
      S_TRACK: begin
        if (w_edge) begin
          w_cnt_nxt = '0;
          w_pv_nxt  = 1'b1;
          if (w_good) begin
            w_mcnt_nxt = w_mcnt_inc;
            if (w_mcnt_inc == c_match) begin
              w_state_nxt = S_LOCK;
            end
          end else begin
            w_mcnt_nxt = 4'd0;
          end
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_mcnt_nxt  = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt + W'(1);
        end
      end
      S_LOCK: begin
        if (w_edge) begin
          w_cnt_nxt = '0;
          w_pv_nxt  = 1'b1;
          if (!w_good) begin
            w_state_nxt = S_TRACK;
            w_mcnt_nxt  = 4'd0;
          end
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_mcnt_nxt  = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt + W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_mcnt_nxt  = 4'd0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_mcnt         <= 4'd0;
      r_detected     <= 1'b0;
      r_half_period  <= '0;
      r_period_valid <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_mcnt         <= w_mcnt_nxt;
      r_detected     <= (w_state_nxt == S_LOCK);
      r_period_valid <= w_pv_nxt;
      if (w_pv_nxt) begin
        r_half_period <= w_meas;
      end
    end
  end

  assign detected     = r_detected;
  assign half_period  = r_half_period;
  assign period_valid = r_period_valid;

endmodule
`default_nettype wire

// File: tb/tb_tone_detect.sv
`default_nettype none
// ============================================================================
// Module   : tb_tone_detect
// Brief    : Directed self-checking bench for tone_detect with HALF=20,
//            TOL=2, MATCH_N=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tone_detect;

  logic        clk;
  logic        rst_n;
  logic        sp_in;
  logic        detected;
  logic [15:0] half_period;
  logic        period_valid;

  int total = 0;
  int bad   = 0;

  tone_detect #(
    .HALF    (20),
    .TOL     (2),
    .MATCH_N (4),
    .W       (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sp_in        (sp_in),
    .detected     (detected),
    .half_period  (half_period),
    .period_valid (period_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Toggle sp_in, then run gap cycles. The edge's result registers on the
  // third clock after the toggle; that sample is returned, and any pulse on
  // the other cycles is counted as stray.
  task automatic tog(input int gap, output logic o_pv, output logic [15:0] o_hp,
                     output logic o_det, output int o_stray);
    o_stray = 0;
    o_pv    = 1'b0;
    o_hp    = '0;
    o_det   = 1'b0;
    sp_in   = ~sp_in;
    for (int i = 1; i <= gap; i++) begin
      step();
      if (i == 3) begin
        o_pv  = period_valid;
        o_hp  = half_period;
        o_det = detected;
      end else if (period_valid !== 1'b0) begin
        o_stray++;
      end
    end
  endtask

  // Play a table of gaps and compare each edge's observed result.
  task automatic run_table(input string name, input int n, input int gap[16],
                           input bit epv[16], input int ehp[16], input bit edet[16]);
    logic        pv, det;
    logic [15:0] hp;
    int          stray;
    for (int k = 0; k < n; k++) begin
      tog(gap[k], pv, hp, det, stray);
      total++;
      if (pv !== epv[k]) begin
        bad++;
        $display("FAIL %s edge%0d period_valid got %b want %b", name, k, pv, epv[k]);
      end
      if (epv[k]) begin
        total++;
        if (hp !== 16'(ehp[k])) begin
          bad++;
          $display("FAIL %s edge%0d half_period got %0d want %0d", name, k, hp, ehp[k]);
        end
      end
      total++;
      if (det !== edet[k]) begin
        bad++;
        $display("FAIL %s edge%0d detected got %b want %b", name, k, det, edet[k]);
      end
      total++;
      if (stray != 0) begin
        bad++;
        $display("FAIL %s edge%0d stray period_valid got %0d want 0", name, k, stray);
      end
    end
  endtask

  task automatic test_reset();
    int pulses;
    int nz;
    rst_n = 1'b0;
    sp_in = 1'b0;
    nz    = 0;
    for (int i = 0; i < 10; i++) begin
      sp_in = ~sp_in;
      step();
      if (detected !== 1'b0 || half_period !== 16'd0 || period_valid !== 1'b0) nz++;
    end
    total++;
    if (nz != 0) begin
      bad++;
      $display("FAIL reset_hold nonzero_output_cycles got %0d want 0", nz);
    end
    sp_in  = 1'b0;
    step();
    rst_n  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (period_valid !== 1'b0) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL reset_static period_valid_pulses got %0d want 0", pulses);
    end
    total++;
    if (detected !== 1'b0) begin
      bad++;
      $display("FAIL reset_static detected got %b want 0", detected);
    end
  endtask

  task automatic test_nominal_lock();
    int gap[16]  = '{20,20,20,20,20,20, 0,0,0,0,0,0,0,0,0,0};
    bit epv[16]  = '{0,1,1,1,1,1, 0,0,0,0,0,0,0,0,0,0};
    int ehp[16]  = '{0,20,20,20,20,20, 0,0,0,0,0,0,0,0,0,0};
    bit edet[16] = '{0,0,0,0,1,1, 0,0,0,0,0,0,0,0,0,0};
    run_table("nominal", 6, gap, epv, ehp, edet);
  endtask

  // From LOCK: a 23 interval (edge in the timeout cycle) drops lock, then a
  // mix of 18/22 builds up; a 17 restarts the match count before relock.
  task automatic test_tolerance();
    int gap[16]  = '{23,18,22,18,17,22,18,22,20,20, 0,0,0,0,0,0};
    bit epv[16]  = '{1,1,1,1,1,1,1,1,1,1, 0,0,0,0,0,0};
    int ehp[16]  = '{20,23,18,22,18,17,22,18,22,20, 0,0,0,0,0,0};
    bit edet[16] = '{1,0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0};
    run_table("tolerance", 10, gap, epv, ehp, edet);
  endtask

  task automatic test_bad_while_locked();
    int gap[16]  = '{17,20,20,20,20,20, 0,0,0,0,0,0,0,0,0,0};
    bit epv[16]  = '{1,1,1,1,1,1, 0,0,0,0,0,0,0,0,0,0};
    int ehp[16]  = '{20,17,20,20,20,20, 0,0,0,0,0,0,0,0,0,0};
    bit edet[16] = '{1,0,0,0,0,1, 0,0,0,0,0,0,0,0,0,0};
    run_table("bad_locked", 6, gap, epv, ehp, edet);
  endtask

  task automatic test_timeout();
    int gap1[16]  = '{25, 0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    bit epv1[16]  = '{1, 0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    int ehp1[16]  = '{20, 0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    bit edet1[16] = '{1, 0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    int gap2[16]  = '{20,20, 0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    bit epv2[16]  = '{0,1, 0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    int ehp2[16]  = '{0,20, 0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    bit edet2[16] = '{0,0, 0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    // Last edge registers 3 clocks after its toggle; 22 clocks later lock holds.
    run_table("timeout_last", 1, gap1, epv1, ehp1, edet1);
    total++;
    if (detected !== 1'b1) begin
      bad++;
      $display("FAIL timeout_early detected got %b want 1", detected);
    end
    step();
    total++;
    if (detected !== 1'b0) begin
      bad++;
      $display("FAIL timeout_drop detected got %b want 0", detected);
    end
    total++;
    if (period_valid !== 1'b0) begin
      bad++;
      $display("FAIL timeout_drop period_valid got %b want 0", period_valid);
    end
    run_table("timeout_rearm", 2, gap2, epv2, ehp2, edet2);
  endtask

  task automatic test_async_reset();
    int gap1[16]  = '{20,20,10, 0,0,0,0,0,0,0,0,0,0,0,0,0};
    bit epv1[16]  = '{1,1,1, 0,0,0,0,0,0,0,0,0,0,0,0,0};
    int ehp1[16]  = '{20,20,20, 0,0,0,0,0,0,0,0,0,0,0,0,0};
    bit edet1[16] = '{0,0,1, 0,0,0,0,0,0,0,0,0,0,0,0,0};
    int gap2[16]  = '{20,20,20,20,20, 0,0,0,0,0,0,0,0,0,0,0};
    bit epv2[16]  = '{0,1,1,1,1, 0,0,0,0,0,0,0,0,0,0,0};
    int ehp2[16]  = '{0,20,20,20,20, 0,0,0,0,0,0,0,0,0,0,0};
    bit edet2[16] = '{0,0,0,0,1, 0,0,0,0,0,0,0,0,0,0,0};
    run_table("async_prelock", 3, gap1, epv1, ehp1, edet1);
    #3;
    total++;
    if (detected !== 1'b1 || half_period !== 16'd20) begin
      bad++;
      $display("FAIL async_before det/hp got %b/%0d want 1/20", detected, half_period);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (detected !== 1'b0 || half_period !== 16'd0 || period_valid !== 1'b0) begin
      bad++;
      $display("FAIL async_clear det/hp/pv got %b/%0d/%b want 0/0/0",
               detected, half_period, period_valid);
    end
    sp_in = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    run_table("async_relock", 5, gap2, epv2, ehp2, edet2);
  endtask

  initial begin
    rst_n = 1'b0;
    sp_in = 1'b0;
    step();
    test_reset();
    test_nominal_lock();
    test_tolerance();
    test_bad_while_locked();
    test_timeout();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
